imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage. It extracts and sign-extends the RISC-V immediate for every base format (I, S, B, U, J) plus the CSR zimm. Output is XLEN wide. Valid/ready handshake on both sides, backed by a 2-entry skid buffer, so decode can stall without dropping instructions. A tag field (PC, rd, etc.) is carried alongside each result.

---
 rtl/imm_gen_pipe.sv | 184 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered RISC-V immediate generator for the decode stage. Decodes the
//   I/S/B/U/J immediates and the CSR zimm from a raw instruction word, extends
//   the result to XLEN, and carries a sideband tag alongside it. A 2-entry
//   skid buffer (main + skid) sits behind a valid/ready handshake on both
//   sides, so the consumer can stall without losing items.
//
//   Optional build macro: IMM_GEN_ERR_EN
//     defined   - an accepted illegal imm_sel (6..7) sets a sticky imm_err
//                 when that item reaches the output (cleared only by reset)
//     undefined - imm_err is tied low, no error state is built
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   TAG_W  sideband tag width
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_ready depends on state only
//   instr, imm_sel      instruction word and format select
//                       (0=I 1=S 2=B 3=U 4=J 5=Z, 6..7 illegal -> 0)
//   in_tag              sideband tag travelling with the instruction
//   out_valid/out_ready output handshake
//   imm_out, out_tag    extended immediate and its tag
//   imm_err             sticky illegal-select flag (see macro above)
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // main full, skid empty
        TWO   = 2'd2    // main and skid full
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t             state_q, state_d;
    entry_t             main_q, skid_q, new_e;
    logic signed [31:0] imm32;
    logic               new_ill;
    logic               in_fire, out_fire;
    logic               load_main_new, load_skid_new, load_main_skid;

    // -------------------------------------------------------------------------
    // Immediate decode. Every format is built as a 32-bit value that is
    // already sign-extended to bit 31, so widening to XLEN is a plain signed
    // extension. Z and illegal results keep bit 31 clear, so they come out
    // zero-extended from the same path.
    // -------------------------------------------------------------------------
    always_comb begin
        imm32   = '0;
        new_ill = 1'b0;
        case (imm_sel)
            3'd0: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'd1: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            3'd3: imm32 = {instr[31:12], 12'b0};
            3'd4: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
            3'd5: imm32 = {27'b0, instr[19:15]};
            default: begin
                imm32   = '0;
                new_ill = 1'b1;
            end
        endcase
    end

    assign new_e.imm = XLEN'(imm32);
    assign new_e.tag = in_tag;

    // -------------------------------------------------------------------------
    // Handshake. in_ready comes from the state register only, so there is no
    // combinational path from out_ready back to in_ready.
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_skid_new  = 1'b0;
        load_main_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d       = ONE;
                    load_main_new = 1'b1;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        state_d       = TWO;
                        load_skid_new = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    // Output drains and a new item arrives in the same cycle:
                    // main simply reloads, the skid stays unused.
                    2'b11: load_main_new = 1'b1;
                    default: state_d = ONE;
                endcase
            end
            TWO: begin
                // in_ready is low here, so only the output side can move.
                if (out_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // -------------------------------------------------------------------------
    // Buffer storage. main_q drives the outputs directly, so they hold while
    // the consumer stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new)       main_q <= new_e;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid_new)       skid_q <= new_e;
        end
    end

    assign imm_out = main_q.imm;
    assign out_tag = main_q.tag;

`ifdef IMM_GEN_ERR_EN
    // The illegal flag follows its item through the buffer; the sticky error
    // is raised on the same edge the item lands in main, i.e. together with
    // its out_valid.
    logic skid_ill_q, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ill_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (load_skid_new) skid_ill_q <= new_ill;
            if ((load_main_new && new_ill) || (load_main_skid && skid_ill_q))
                err_q <= 1'b1;
        end
    end

    assign imm_err = err_q;
`else
    logic unused_ill;
    assign unused_ill = new_ill;
    assign imm_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. A 32-bit and a 64-bit instance share the
//   same stimulus; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready64;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic [7:0]  in_tag;
    logic        out_valid, out_valid64;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [63:0] imm_out64;
    logic [7:0]  out_tag, out_tag64;
    logic        imm_err, imm_err64;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef IMM_GEN_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .out_tag(out_tag), .imm_err(imm_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm_out64), .out_tag(out_tag64), .imm_err(imm_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Present one item for one cycle, then sample 1 time unit after the edge.
    task automatic push(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
        in_valid = 1'b1;
        instr    = i;
        imm_sel  = s;
        in_tag   = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr    = 32'hDEADBEEF;   // must be ignored while in_valid is low
        imm_sel  = 3'd2;
        in_tag   = 8'hEE;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        imm_sel   = '0;
        in_tag    = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_imm_out",   64'(imm_out),   64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_imm_err",   64'(imm_err),   64'd0);
        chk("rst_imm_out64", imm_out64,      64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Formats, streaming with out_ready high
        push(32'hFFF00093, 3'd0, 8'h11);
        chk("i_valid",  64'(out_valid), 64'd1);
        chk("i_imm",    64'(imm_out),   64'h0000_0000_FFFF_FFFF);
        chk("i_tag",    64'(out_tag),   64'h11);
        chk("i_imm64",  imm_out64,      64'hFFFF_FFFF_FFFF_FFFF);

        push(32'h00A12423, 3'd1, 8'h12);
        chk("s_pos_imm", 64'(imm_out), 64'h0000_0008);
        push(32'hFE112E23, 3'd1, 8'h13);
        chk("s_neg_imm", 64'(imm_out), 64'hFFFF_FFFC);
        chk("s_neg_tag", 64'(out_tag), 64'h13);

        push(32'hFE000EE3, 3'd2, 8'h14);
        chk("b_imm",   64'(imm_out), 64'hFFFF_FFFC);
        chk("b_imm64", imm_out64,    64'hFFFF_FFFF_FFFF_FFFC);
        push(32'hFF9FF06F, 3'd4, 8'h15);
        chk("j_imm",   64'(imm_out), 64'hFFFF_FFF8);

        push(32'h123450B7, 3'd3, 8'h16);
        chk("u_imm",   64'(imm_out), 64'h1234_5000);
        chk("u_imm64", imm_out64,    64'h0000_0000_1234_5000);
        push(32'h000FD073, 3'd5, 8'h17);
        chk("z_imm",   64'(imm_out), 64'h0000_001F);
        chk("z_imm64", imm_out64,    64'h0000_0000_0000_001F);

        push(32'h800000B7, 3'd3, 8'h18);
        chk("u_neg_imm",   64'(imm_out), 64'h8000_0000);
        chk("u_neg_imm64", imm_out64,    64'hFFFF_FFFF_8000_0000);
        chk("no_err_yet",  64'(imm_err), 64'd0);

        // Drain
        @(posedge clk); #1;
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: three back-to-back items with the consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr = 32'h00100093; imm_sel = 3'd0; in_tag = 8'd1;
        @(posedge clk); #1;
        chk("bp1_valid", 64'(out_valid), 64'd1);
        chk("bp1_tag",   64'(out_tag),   64'd1);
        chk("bp1_ready", 64'(in_ready),  64'd1);
        instr = 32'h00200093; in_tag = 8'd2;
        @(posedge clk); #1;
        chk("bp2_ready", 64'(in_ready),   64'd0);
        chk("bp2_tag",   64'(out_tag),    64'd1);
        chk("bp2_ready64", 64'(in_ready64), 64'd0);
        instr = 32'h00300093; in_tag = 8'd3;
        @(posedge clk); #1;
        chk("bp_stall_tag",   64'(out_tag),  64'd1);
        chk("bp_stall_imm",   64'(imm_out),  64'd1);
        chk("bp_stall_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;   // tag 3 still offered, not yet accepted
        @(posedge clk); #1;
        chk("bp_out2_tag",   64'(out_tag),  64'd2);
        chk("bp_out2_imm",   64'(imm_out),  64'd2);
        chk("bp_out2_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_out3_tag", 64'(out_tag), 64'd3);
        chk("bp_out3_imm", 64'(imm_out), 64'd3);
        @(posedge clk); #1;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Illegal selects and sticky error
        push(32'h12345678, 3'd7, 8'h77);
        chk("ill7_imm", 64'(imm_out), 64'd0);
        chk("ill7_tag", 64'(out_tag), 64'h77);
        chk("ill7_err", 64'(imm_err), 64'(ERR_EXP));
        push(32'h00500093, 3'd0, 8'h78);
        chk("sticky_imm", 64'(imm_out), 64'd5);
        chk("sticky_err", 64'(imm_err), 64'(ERR_EXP));
        push(32'hFFFFFFFF, 3'd6, 8'h79);
        chk("ill6_imm",   64'(imm_out), 64'd0);
        chk("ill6_imm64", imm_out64,    64'd0);

        // Reset mid-stream with both entries full
        out_ready = 1'b0;
        @(posedge clk); #1;   // drain the illegal item is blocked; hold it
        push(32'h00100093, 3'd0, 8'h7A);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready),  64'd1);
        chk("arst_err",   64'(imm_err),   64'd0);
        chk("arst_imm",   64'(imm_out),   64'd0);
        chk("arst_tag",   64'(out_tag),   64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(32'h00A00093, 3'd0, 8'h5A);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_imm",   64'(imm_out),   64'h0A);
        chk("post_rst_tag",   64'(out_tag),   64'h5A);
        @(posedge clk); #1;
        chk("post_rst_drain", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
